// File: rtl/laser_cover_checker.sv
// Purpose: counts how many stored laser targets fall inside circle C1, circle C2,
//          their union and their overlap, after the placement block signals DONE.
// Ports:
//   CLK, RST            clock and synchronous active-high reset (also starts a new pattern)
//   X, Y                target coordinates, one per cycle while capturing
//   C1X, C1Y, C2X, C2Y  circle centres, sampled when DONE is accepted
//   DONE                result-ready pulse from the placement block
//   COVER_CNT           targets inside C1 or C2
//   BOTH_CNT            targets inside both C1 and C2
//   MISS                COVER_CNT below MIN_COVER
//   VALID               one-cycle pulse marking updated results
module laser_cover_checker #(
  parameter int unsigned N_TARGETS = 40,
  parameter int unsigned RADIUS_SQ = 16,
  parameter int unsigned MIN_COVER = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  input  logic       DONE,
  output logic [5:0] COVER_CNT,
  output logic [5:0] BOTH_CNT,
  output logic       MISS,
  output logic       VALID
);

  localparam int unsigned IDX_W   = 6;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned DSQ_W   = 9;
  localparam int unsigned DIFF_W  = CNT_W + 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TARGETS - 1);

  localparam logic [1:0] ST_CAPTURE = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_SCAN    = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [COORD_W-1:0] c1x, c1y, c2x, c2y;
  logic [COORD_W-1:0] c1x_nxt, c1y_nxt, c2x_nxt, c2y_nxt;
  logic [CNT_W-1:0]   acc_union, acc_union_nxt;
  logic [CNT_W-1:0]   acc_both, acc_both_nxt;
  logic [CNT_W-1:0]   cover_nxt, both_nxt;
  logic               miss_nxt, valid_nxt;

  logic [2*COORD_W-1:0] mem [N_TARGETS];
  logic [2*COORD_W-1:0] tgt;
  logic [DSQ_W-1:0]     dsq1, dsq2;
  logic                 in1, in2;
  logic [CNT_W-1:0]     union_sum, both_sum;
  logic [DIFF_W-1:0]    miss_diff;

  // Absolute difference without wrap: subtract the smaller from the larger.
  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Squared Euclidean distance; 9 bits holds the worst case 15^2 + 15^2 = 450.
  function automatic logic [DSQ_W-1:0] dist_sq(input logic [COORD_W-1:0] tx,
                                               input logic [COORD_W-1:0] ty,
                                               input logic [COORD_W-1:0] cx,
                                               input logic [COORD_W-1:0] cy);
    logic [2*COORD_W-1:0] dx, dy;
    dx = (2*COORD_W)'(abs_diff(tx, cx));
    dy = (2*COORD_W)'(abs_diff(ty, cy));
    return DSQ_W'(dx * dx) + DSQ_W'(dy * dy);
  endfunction

  // Target store; contents are meaningless until a full capture completes.
  always_ff @(posedge CLK) begin
    if (!RST && state == ST_CAPTURE) begin
      mem[idx] <= {X, Y};
    end
  end

  // Coverage test of the target currently addressed during the scan.
  always_comb begin
    tgt       = mem[idx];
    dsq1      = dist_sq(tgt[7:4], tgt[3:0], c1x, c1y);
    dsq2      = dist_sq(tgt[7:4], tgt[3:0], c2x, c2y);
    in1       = (32'(dsq1) <= RADIUS_SQ);
    in2       = (32'(dsq2) <= RADIUS_SQ);
    union_sum = acc_union + CNT_W'(in1 | in2);
    both_sum  = acc_both + CNT_W'(in1 & in2);
    // Sign bit of (union - MIN_COVER) flags union < MIN_COVER.
    miss_diff = DIFF_W'(union_sum) - DIFF_W'(MIN_COVER);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    c1x_nxt       = c1x;
    c1y_nxt       = c1y;
    c2x_nxt       = c2x;
    c2y_nxt       = c2y;
    acc_union_nxt = acc_union;
    acc_both_nxt  = acc_both;
    cover_nxt     = COVER_CNT;
    both_nxt      = BOTH_CNT;
    miss_nxt      = MISS;
    valid_nxt     = 1'b0;

    case (state)
      ST_CAPTURE: begin
        if (idx == LAST_IDX) begin
          idx_nxt   = '0;
          state_nxt = ST_WAIT;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      ST_WAIT: begin
        if (DONE) begin
          c1x_nxt       = C1X;
          c1y_nxt       = C1Y;
          c2x_nxt       = C2X;
          c2y_nxt       = C2Y;
          acc_union_nxt = '0;
          acc_both_nxt  = '0;
          idx_nxt       = '0;
          state_nxt     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        acc_union_nxt = union_sum;
        acc_both_nxt  = both_sum;
        if (idx == LAST_IDX) begin
          idx_nxt   = '0;
          cover_nxt = union_sum;
          both_nxt  = both_sum;
          miss_nxt  = miss_diff[DIFF_W-1];
          valid_nxt = 1'b1;
          state_nxt = ST_HOLD;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      default: begin
        // HOLD: results stay until the next reset; DONE is ignored.
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_CAPTURE;
      idx       <= '0;
      c1x       <= '0;
      c1y       <= '0;
      c2x       <= '0;
      c2y       <= '0;
      acc_union <= '0;
      acc_both  <= '0;
      COVER_CNT <= '0;
      BOTH_CNT  <= '0;
      MISS      <= 1'b0;
      VALID     <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      c1x       <= c1x_nxt;
      c1y       <= c1y_nxt;
      c2x       <= c2x_nxt;
      c2y       <= c2y_nxt;
      acc_union <= acc_union_nxt;
      acc_both  <= acc_both_nxt;
      COVER_CNT <= cover_nxt;
      BOTH_CNT  <= both_nxt;
      MISS      <= miss_nxt;
      VALID     <= valid_nxt;
    end
  end

endmodule
